// File: rtl/rggen_rtl_pkg.sv
// Shared rggen register-bus types used by bus-side blocks.
// Holds access/status encodings and the bus arbiter state enum.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_READ         = 2'b10,
        RGGEN_WRITE        = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic {
        RGGEN_ARBITER_IDLE,
        RGGEN_ARBITER_GRANT
    } rggen_arbiter_state;

    // Index width that stays at least one bit for single-entry vectors.
    function automatic int rggen_clog2(int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rggen_round_robin_select.sv
// Combinational round-robin pick: first request at or above the
// pointer, wrapping around; returns one-hot grant and its index.
module rggen_round_robin_select
    import rggen_rtl_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = rggen_clog2(N)
)(
    input  logic [N-1:0]  request,
    input  logic [IW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    int   slot;
    logic hit;

    // Scan N slots starting at the pointer; the first hit wins.
    always_comb begin
        grant = '0;
        index = '0;
        hit   = 1'b0;
        slot  = 0;
        for (int i = 0; i < N; i++) begin
            slot = (int'(pointer) + i) % N;
            if (!hit && request[slot]) begin
                hit         = 1'b1;
                grant[slot] = 1'b1;
                index       = IW'(slot);
            end
        end
    end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Round-robin sharing of one rggen bus port among HOSTS hosts.
// Optional watchdog: define RGGEN_BUS_ARBITER_TIMEOUT_EN.
module rggen_bus_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int HOSTS          = 2,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int STROBE_WIDTH   = BUS_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 256
)(
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic [HOSTS-1:0]                    i_valid,
    input  rggen_access [HOSTS-1:0]             i_access,
    input  logic [HOSTS-1:0][ADDRESS_WIDTH-1:0] i_address,
    input  logic [HOSTS-1:0][BUS_WIDTH-1:0]     i_write_data,
    input  logic [HOSTS-1:0][STROBE_WIDTH-1:0]  i_strobe,
    output logic [HOSTS-1:0]                    o_ready,
    output rggen_status                         o_status,
    output logic [BUS_WIDTH-1:0]                o_read_data,
    output logic                                o_bus_valid,
    output rggen_access                         o_bus_access,
    output logic [ADDRESS_WIDTH-1:0]            o_bus_address,
    output logic [BUS_WIDTH-1:0]                o_bus_write_data,
    output logic [STROBE_WIDTH-1:0]             o_bus_strobe,
    input  logic                                i_bus_ready,
    input  rggen_status                         i_bus_status,
    input  logic [BUS_WIDTH-1:0]                i_bus_read_data
);

    localparam int INDEX_WIDTH = rggen_clog2(HOSTS);

    rggen_arbiter_state     state;
    rggen_arbiter_state     state_next;
    logic [INDEX_WIDTH-1:0] grant_index;
    logic [INDEX_WIDTH-1:0] pointer;
    logic [INDEX_WIDTH-1:0] pointer_next;
    logic [INDEX_WIDTH-1:0] select_index;
    logic [HOSTS-1:0]       select_grant;
    logic                   in_grant;
    logic                   timeout;
    logic                   complete;

    rggen_round_robin_select #(
        .N  (HOSTS),
        .IW (INDEX_WIDTH)
    ) u_select (
        .request (i_valid),
        .pointer (pointer),
        .grant   (select_grant),
        .index   (select_index)
    );

    assign in_grant = (state == RGGEN_ARBITER_GRANT);
    assign complete = in_grant && (i_bus_ready || timeout);

    assign pointer_next =
        (grant_index == INDEX_WIDTH'(HOSTS - 1)) ? '0
                                                 : grant_index + 1'b1;

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
    localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [COUNT_WIDTH-1:0] count;

    // Watchdog: zero outside GRANT, counts GRANT cycles without ready.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
        end else if (!in_grant) begin
            count <= '0;
        end else if (!i_bus_ready) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = in_grant && !i_bus_ready &&
                     (count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= RGGEN_ARBITER_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant index latched on acceptance; pointer moves past it on completion.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            grant_index <= '0;
            pointer     <= '0;
        end else begin
            if (!in_grant && (|select_grant)) begin
                grant_index <= select_index;
            end
            if (complete) begin
                pointer <= pointer_next;
            end
        end
    end

    // Next state and response routing to the granted host only.
    always_comb begin
        state_next  = state;
        o_bus_valid = 1'b0;
        o_ready     = '0;
        o_status    = RGGEN_OKAY;
        o_read_data = '0;
        unique case (state)
            RGGEN_ARBITER_IDLE: begin
                if (|select_grant) begin
                    state_next = RGGEN_ARBITER_GRANT;
                end
            end
            RGGEN_ARBITER_GRANT: begin
                o_bus_valid = 1'b1;
                if (complete) begin
                    state_next           = RGGEN_ARBITER_IDLE;
                    o_ready[grant_index] = 1'b1;
                    if (i_bus_ready) begin
                        o_status    = i_bus_status;
                        o_read_data = i_bus_read_data;
                    end else begin
                        o_status    = RGGEN_SLAVE_ERROR;
                    end
                end
            end
            default: begin
                state_next = RGGEN_ARBITER_IDLE;
            end
        endcase
    end

    assign o_bus_access     = i_access[grant_index];
    assign o_bus_address    = i_address[grant_index];
    assign o_bus_write_data = i_write_data[grant_index];
    assign o_bus_strobe     = i_strobe[grant_index];

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Directed table-driven bench for rggen_bus_arbiter with four hosts.
// Watchdog sequence runs when RGGEN_BUS_ARBITER_TIMEOUT_EN is defined.
module tb_rggen_bus_arbiter;
    import rggen_rtl_pkg::*;

    localparam int H = 4;

    logic                 clk;
    logic                 rst;
    logic [H-1:0]         valid;
    rggen_access [H-1:0]  access;
    logic [H-1:0][7:0]    address;
    logic [H-1:0][31:0]   write_data;
    logic [H-1:0][3:0]    strobe;
    logic [H-1:0]         ready;
    rggen_status          status;
    logic [31:0]          read_data;
    logic                 bus_valid;
    rggen_access          bus_access;
    logic [7:0]           bus_address;
    logic [31:0]          bus_write_data;
    logic [3:0]           bus_strobe;
    logic                 bus_ready;
    rggen_status          bus_status;
    logic [31:0]          bus_read_data;

    int n_checks = 0;
    int n_fail   = 0;

    rggen_bus_arbiter #(
        .HOSTS          (H),
        .ADDRESS_WIDTH  (8),
        .BUS_WIDTH      (32),
        .STROBE_WIDTH   (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_valid          (valid),
        .i_access         (access),
        .i_address        (address),
        .i_write_data     (write_data),
        .i_strobe         (strobe),
        .o_ready          (ready),
        .o_status         (status),
        .o_read_data      (read_data),
        .o_bus_valid      (bus_valid),
        .o_bus_access     (bus_access),
        .o_bus_address    (bus_address),
        .o_bus_write_data (bus_write_data),
        .o_bus_strobe     (bus_strobe),
        .i_bus_ready      (bus_ready),
        .i_bus_status     (bus_status),
        .i_bus_read_data  (bus_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic        rst;
        logic        bus_ready;
        rggen_status bus_status;
        logic [31:0] bus_data;
        logic        exp_bv;
        int          exp_host;
        logic [3:0]  exp_ready;
        rggen_status exp_status;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    rggen_access tab_access[H];
    logic [7:0]  tab_addr[H];
    logic [31:0] tab_wdata[H];
    logic [3:0]  tab_strb[H];

    function automatic void add(
        logic [3:0] v, logic r, logic br, rggen_status bs, logic [31:0] bd,
        logic ebv, int eh, logic [3:0] er, rggen_status es, logic [31:0] ed
    );
        vec_t t;
        t.valid = v;  t.rst = r;  t.bus_ready = br;
        t.bus_status = bs;  t.bus_data = bd;
        t.exp_bv = ebv;  t.exp_host = eh;  t.exp_ready = er;
        t.exp_status = es;  t.exp_data = ed;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_cycle(input int idx, input logic ebv, input int eh,
                             input logic [3:0] er, input rggen_status es,
                             input logic [31:0] ed);
        chk("bus_valid", idx, 32'(bus_valid), 32'(ebv));
        chk("ready", idx, 32'(ready), 32'(er));
        chk("status", idx, 32'(status), 32'(es));
        chk("read_data", idx, read_data, ed);
        if (ebv) begin
            chk("bus_access", idx, 32'(bus_access), 32'(tab_access[eh]));
            chk("bus_address", idx, 32'(bus_address), 32'(tab_addr[eh]));
            chk("bus_write_data", idx, bus_write_data, tab_wdata[eh]);
            chk("bus_strobe", idx, 32'(bus_strobe), 32'(tab_strb[eh]));
        end
    endtask

    localparam rggen_status O = RGGEN_OKAY;
    localparam rggen_status S = RGGEN_SLAVE_ERROR;

    initial begin
        tab_access[0] = RGGEN_READ;   tab_addr[0] = 8'h04;
        tab_access[1] = RGGEN_READ;   tab_addr[1] = 8'h10;
        tab_access[2] = RGGEN_WRITE;  tab_addr[2] = 8'h28;
        tab_access[3] = RGGEN_WRITE;  tab_addr[3] = 8'h3C;
        tab_wdata[0] = 32'h1111_0000; tab_strb[0] = 4'hF;
        tab_wdata[1] = 32'h2222_0001; tab_strb[1] = 4'hF;
        tab_wdata[2] = 32'h3333_0002; tab_strb[2] = 4'h3;
        tab_wdata[3] = 32'hA5A5_5A5A; tab_strb[3] = 4'b0101;
        for (int h = 0; h < H; h++) begin
            access[h]     = tab_access[h];
            address[h]    = tab_addr[h];
            write_data[h] = tab_wdata[h];
            strobe[h]     = tab_strb[h];
        end

        // All hosts request, downstream ready at once: 0,1,2,3,0.
        add(4'hF, 0, 1, O, 32'hA000_0000, 0, 0, 4'h0, O, 32'h0);
        add(4'hF, 0, 1, O, 32'hA000_00A0, 1, 0, 4'h1, O, 32'hA000_00A0);
        add(4'hF, 0, 1, O, 32'hA000_00A1, 0, 0, 4'h0, O, 32'h0);
        add(4'hF, 0, 1, O, 32'hA000_00A1, 1, 1, 4'h2, O, 32'hA000_00A1);
        add(4'hF, 0, 1, O, 32'hA000_00A2, 0, 0, 4'h0, O, 32'h0);
        add(4'hF, 0, 1, O, 32'hA000_00A2, 1, 2, 4'h4, O, 32'hA000_00A2);
        add(4'hF, 0, 1, O, 32'hA000_00A3, 0, 0, 4'h0, O, 32'h0);
        add(4'hF, 0, 1, O, 32'hA000_00A3, 1, 3, 4'h8, O, 32'hA000_00A3);
        add(4'hF, 0, 1, O, 32'hA000_00A4, 0, 0, 4'h0, O, 32'h0);
        add(4'hF, 0, 1, O, 32'hA000_00A4, 1, 0, 4'h1, O, 32'hA000_00A4);
        // Pointer at 1: host 2 beats host 0, then host 0 before late host 3.
        add(4'h5, 0, 0, O, 32'h0, 0, 0, 4'h0, O, 32'h0);
        add(4'h5, 0, 0, O, 32'h0, 1, 2, 4'h0, O, 32'h0);
        add(4'h5, 0, 1, O, 32'hC2, 1, 2, 4'h4, O, 32'hC2);
        add(4'h1, 0, 0, O, 32'h0, 0, 0, 4'h0, O, 32'h0);
        add(4'h9, 0, 1, S, 32'hC4, 1, 0, 4'h1, S, 32'hC4);
        add(4'h8, 0, 0, O, 32'h0, 0, 0, 4'h0, O, 32'h0);
        add(4'h8, 0, 0, O, 32'h0, 1, 3, 4'h0, O, 32'h0);
        add(4'h8, 0, 0, O, 32'h0, 1, 3, 4'h0, O, 32'h0);
        add(4'h8, 0, 1, O, 32'h0, 1, 3, 4'h8, O, 32'h0);
        add(4'h0, 0, 0, O, 32'h0, 0, 0, 4'h0, O, 32'h0);
        // Host 1 read, downstream ready on the third GRANT cycle.
        add(4'h2, 0, 0, O, 32'h0, 0, 0, 4'h0, O, 32'h0);
        add(4'h2, 0, 0, O, 32'h0, 1, 1, 4'h0, O, 32'h0);
        add(4'h2, 0, 0, O, 32'h0, 1, 1, 4'h0, O, 32'h0);
        add(4'h2, 0, 1, O, 32'hDEADBEEF, 1, 1, 4'h2, O, 32'hDEADBEEF);
        add(4'h0, 0, 1, O, 32'hCAFEF00D, 0, 0, 4'h0, O, 32'h0);
        // Reset during GRANT abandons host 1; host 0 then wins the tie.
        add(4'h2, 0, 0, O, 32'h0, 0, 0, 4'h0, O, 32'h0);
        add(4'h2, 1, 0, O, 32'h0, 1, 1, 4'h0, O, 32'h0);
        add(4'h3, 0, 1, O, 32'hBBBB, 0, 0, 4'h0, O, 32'h0);
        add(4'h3, 0, 1, O, 32'h5353, 1, 0, 4'h1, O, 32'h5353);
        add(4'h2, 0, 0, O, 32'h0, 0, 0, 4'h0, O, 32'h0);
        add(4'h2, 0, 1, O, 32'h5555, 1, 1, 4'h2, O, 32'h5555);
        add(4'h0, 0, 0, O, 32'h0, 0, 0, 4'h0, O, 32'h0);

        rst = 1'b1;
        valid = '0;
        bus_ready = 1'b0;
        bus_status = O;
        bus_read_data = '0;
        @(posedge clk);
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            valid         = vecs[i].valid;
            rst           = vecs[i].rst;
            bus_ready     = vecs[i].bus_ready;
            bus_status    = vecs[i].bus_status;
            bus_read_data = vecs[i].bus_data;
            #1;
            chk_cycle(i, vecs[i].exp_bv, vecs[i].exp_host,
                      vecs[i].exp_ready, vecs[i].exp_status,
                      vecs[i].exp_data);
        end

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
        // Pointer is 2: host 0 granted, downstream never answers.
        @(negedge clk);
        valid = 4'h3; bus_ready = 1'b0; bus_read_data = 32'h1234_5678;
        #1;
        chk_cycle(100, 0, 0, 4'h0, O, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            #1;
            if (k < 8) chk_cycle(100 + k, 1, 0, 4'h0, O, 32'h0);
            else       chk_cycle(100 + k, 1, 0, 4'h1, S, 32'h0);
        end
        @(negedge clk);
        valid = 4'h2;
        #1;
        chk_cycle(109, 0, 0, 4'h0, O, 32'h0);
        @(negedge clk);
        bus_ready = 1'b1; bus_read_data = 32'h0000_7777;
        #1;
        chk_cycle(110, 1, 1, 4'h2, O, 32'h0000_7777);
        @(negedge clk);
        valid = '0; bus_ready = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
